// File: rtl/sensor_bus_pkg.sv
// Shared definitions for the sensor bus link: slot encoding, sample width,
// default clamp limits and the A/B sample pair type.
package sensor_bus_pkg;

  localparam int SENSOR_W = 8;

  // Slot encoding doubles as the ss line value.
  localparam logic [0:0] SLOT_A = 1'b0;
  localparam logic [0:0] SLOT_B = 1'b1;

  localparam logic [SENSOR_W-1:0] DEF_MIN_VAL = 8'd1;
  localparam logic [SENSOR_W-1:0] DEF_MAX_VAL = 8'd100;

  typedef struct packed {
    logic [SENSOR_W-1:0] a;
    logic [SENSOR_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO with power-of-two depth, wrap-around pointers and an
// occupancy count. Pushes when full and pops when empty are ignored.
module pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign do_push  = push && !full;
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sensor_pair_tx.sv
// Transmit side of the shared sensor bus: clamps and queues A/B sample pairs,
// then sends them as fixed two-cycle frames (A on ss=0, B on ss=1).
module sensor_pair_tx
  import sensor_bus_pkg::*;
#(
  parameter int                  DEPTH   = 2,
  parameter logic [SENSOR_W-1:0] MIN_VAL = DEF_MIN_VAL,
  parameter logic [SENSOR_W-1:0] MAX_VAL = DEF_MAX_VAL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SENSOR_W-1:0] in_a,
  input  logic [SENSOR_W-1:0] in_b,
  output logic [SENSOR_W-1:0] data_bus,
  output logic                ss,
  output logic                frame_start,
  output logic                sent,
  output logic                clamped
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [SENSOR_W-1:0] clamp_val(input logic [SENSOR_W-1:0] v);
    if (v < MIN_VAL)      return MIN_VAL;
    else if (v > MAX_VAL) return MAX_VAL;
    else                  return v;
  endfunction

  function automatic logic out_of_range(input logic [SENSOR_W-1:0] v);
    return (v < MIN_VAL) || (v > MAX_VAL);
  endfunction

  logic [0:0]          state;
  logic                accept;
  logic                pop;
  logic                full;
  logic [CW-1:0]       count;
  pair_t               push_pair;
  pair_t               head;
  logic [SENSOR_W-1:0] hold_b;
  logic                data_frame;

  assign in_ready  = !full;
  assign accept    = rst_n && in_valid && in_ready;
  assign clamped   = accept && (out_of_range(in_a) || out_of_range(in_b));
  assign push_pair = '{a: clamp_val(in_a), b: clamp_val(in_b)};

  // Pop decision uses the pre-edge count, so a pair pushed on the same
  // SLOT_A-entry edge into an empty FIFO waits for the next frame.
  assign pop = (state == SLOT_B) && (count != '0);

  pair_fifo #(
    .WIDTH ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_pair),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full)
  );

  // Free-running frame FSM: alternates every cycle, phase fixed by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SLOT_A;
      ss          <= 1'b0;
      data_bus    <= '0;
      hold_b      <= '0;
      data_frame  <= 1'b0;
      frame_start <= 1'b0;
      sent        <= 1'b0;
    end else if (state == SLOT_B) begin
      state       <= SLOT_A;
      ss          <= SLOT_A;
      data_frame  <= pop;
      frame_start <= pop;
      sent        <= 1'b0;
      data_bus    <= pop ? head.a : '0;
      hold_b      <= pop ? head.b : '0;
    end else begin
      state       <= SLOT_B;
      ss          <= SLOT_B;
      frame_start <= 1'b0;
      sent        <= data_frame;
      data_bus    <= data_frame ? hold_b : '0;
    end
  end

endmodule

// File: tb/tb_sensor_pair_tx.sv
// Directed bench for sensor_pair_tx: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_sensor_pair_tx;
  import sensor_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [7:0] data_bus;
  logic       ss;
  logic       frame_start;
  logic       sent;
  logic       clamped;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sensor_pair_tx #(.DEPTH(2), .MIN_VAL(8'd1), .MAX_VAL(8'd100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .data_bus    (data_bus),
    .ss          (ss),
    .frame_start (frame_start),
    .sent        (sent),
    .clamped     (clamped)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       rdy;
    logic       clp;
    logic       ss;
    logic [7:0] d;
    logic       fs;
    logic       snt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic rdy, input logic clp, input logic s,
                     input logic [7:0] d, input logic fs, input logic snt);
    vec_t r;
    r = '{v: v, a: a, b: b, rdy: rdy, clp: clp, ss: s, d: d, fs: fs, snt: snt};
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic [7:0] d,
                         input logic fs, input logic snt);
    chk({tag, "_ss"}, 16'(ss), 16'(s));
    chk({tag, "_data"}, 16'(data_bus), 16'(d));
    chk({tag, "_frame_start"}, 16'(frame_start), 16'(fs));
    chk({tag, "_sent"}, 16'(sent), 16'(snt));
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //   v  a    b    rdy clp ss data fs snt
    // Idle after reset release
    add(0, 0,   0,   1,  0,  1, 0,   0, 0);
    add(0, 0,   0,   1,  0,  0, 0,   0, 0);
    add(0, 0,   0,   1,  0,  1, 0,   0, 0);
    add(0, 0,   0,   1,  0,  0, 0,   0, 0);
    // Single pair accepted on an A->B edge: sent on the next frame
    add(1, 40,  75,  1,  0,  1, 0,   0, 0);
    add(0, 0,   0,   1,  0,  0, 40,  1, 0);
    add(0, 0,   0,   1,  0,  1, 75,  0, 1);
    add(0, 0,   0,   1,  0,  0, 0,   0, 0);
    add(0, 0,   0,   1,  0,  1, 0,   0, 0);
    // Clamp, accepted on a B->A edge into an empty FIFO: waits one frame
    add(1, 0,   200, 1,  1,  0, 0,   0, 0);
    add(0, 0,   0,   1,  0,  1, 0,   0, 0);
    add(0, 0,   0,   1,  0,  0, 1,   1, 0);
    add(0, 0,   0,   1,  0,  1, 100, 0, 1);
    // Back-pressure with in_valid held
    add(1, 10,  11,  1,  0,  0, 0,   0, 0);
    add(1, 12,  13,  1,  0,  1, 0,   0, 0);
    add(1, 14,  15,  0,  0,  0, 10,  1, 0);
    add(1, 14,  15,  1,  0,  1, 11,  0, 1);
    add(1, 16,  17,  0,  0,  0, 12,  1, 0);
    add(1, 16,  17,  1,  0,  1, 13,  0, 1);
    add(0, 0,   0,   0,  0,  0, 14,  1, 0);
    add(0, 0,   0,   1,  0,  1, 15,  0, 1);
    add(0, 0,   0,   1,  0,  0, 16,  1, 0);
    add(0, 0,   0,   1,  0,  1, 17,  0, 1);
    add(0, 0,   0,   1,  0,  0, 0,   0, 0);
    // Push and pop on the same SLOT_A-entry edge
    add(1, 20,  21,  1,  0,  1, 0,   0, 0);
    add(1, 22,  23,  1,  0,  0, 20,  1, 0);
    add(0, 0,   0,   1,  0,  1, 21,  0, 1);
    add(0, 0,   0,   1,  0,  0, 22,  1, 0);
    add(0, 0,   0,   1,  0,  1, 23,  0, 1);
    add(0, 0,   0,   1,  0,  0, 0,   0, 0);

    // Reset held 3 cycles with an out-of-range offer that must be ignored
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd0;
    in_b = 8'd200;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("reset_ready", 16'(in_ready), 16'd1);
    chk("reset_clamped", 16'(clamped), 16'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v;
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      #1;
      chk($sformatf("v%0d_ready", i), 16'(in_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d_clamped", i), 16'(clamped), 16'(vecs[i].clp));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].ss, vecs[i].d, vecs[i].fs, vecs[i].snt);
    end

    // Queue two pairs, then reset during SLOT_B
    step(1'b1, 8'd30, 8'd31);
    chk_out("mid_q0", 1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd32, 8'd33);
    chk_out("mid_q1", 1'b0, 8'd30, 1'b1, 1'b0);
    step(1'b1, 8'd34, 8'd35);
    chk_out("mid_q2", 1'b1, 8'd31, 1'b0, 1'b1);
    chk("mid_full", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_out("mid_rst", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("mid_rst_ready", 16'(in_ready), 16'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 8'd0, 8'd0);
      chk_out($sformatf("post_rst%0d", k), (k % 2 == 0) ? 1'b1 : 1'b0, 8'd0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_pair_tx.md
# sensor_pair_tx

Transmit side of the shared sensor bus. Accepts paired 8-bit sensor samples (channel A, channel B) through a valid/ready handshake, buffers them in a small FIFO, and drives them onto the 8-bit `data_bus`/`ss` link as fixed two-cycle frames (A on `ss=0`, B on `ss=1`) for the pair receiver. Idle frames carry zeros so the receiver never re-emits stale pairs.

## Interface

**Parameters**

- `DEPTH`, 2: pair FIFO depth; power of two, at least 2.
- `MIN_VAL`, 1: lower clamp for sample values. Must be nonzero, because a zero value would suppress the frame at the receiver.
- `MAX_VAL`, 100: upper clamp for sample values (moisture percent range).

**Ports** (clock and reset first)

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `in_valid`, in, 1: a sample pair is offered.
- `in_ready`, out, 1: FIFO not full.
- `in_a`, in, 8: channel A sample.
- `in_b`, in, 8: channel B sample.
- `data_bus`, out, 8: registered bus value.
- `ss`, out, 1: registered slot select; 0 means slot A, 1 means slot B.
- `frame_start`, out, 1: 1-cycle pulse, high while slot A of a data (non-idle) frame is driven.
- `sent`, out, 1: 1-cycle pulse, high while slot B of a data frame is driven.
- `clamped`, out, 1: 1-cycle pulse on the accept cycle when either input was clamped.

## Operation

**Frame FSM**
- Two states: `SLOT_A` and `SLOT_B`.
- The state toggles on every clock edge with no stall, so frame alignment is fixed by reset release. This matches the receiver, which counts every cycle.
- Frame type is decided on entry to `SLOT_A`:
  - FIFO non-empty: pop the head pair, drive `data_bus = a`, `ss = 0`, and set `frame_start`. Hold `b` in a register.
  - FIFO empty: idle frame. Drive `data_bus = 0`, `ss = 0`.
- On entry to `SLOT_B`: drive `ss = 1` and `data_bus` = the held `b`, or 0 for an idle frame. Set `sent` for a data frame.

**Accept path**
- A pair is accepted when `in_valid && in_ready` at a clock edge.
- Each value is clamped before storage: below `MIN_VAL` becomes `MIN_VAL`, above `MAX_VAL` becomes `MAX_VAL`.
- `clamped` is asserted in that same cycle (combinational from inputs, gated by accept).

**FIFO**
- `DEPTH` entries of 16 bits, {a, b}.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Occupancy count is `$clog2(DEPTH)+1` bits.
- `in_ready = (count != DEPTH)`, registered-state based.
- Push and pop in the same edge: both happen and count is unchanged.
- Push into an empty FIFO on the edge that enters `SLOT_A`: not popped that edge, because pop uses pre-edge count. It is sent in the next frame.

**Reset** (all values take effect on the edge where `rst_n = 0`)
- `ss = 0`, `data_bus = 0`, state `SLOT_A`, held `b = 0`.
- FIFO empty, `in_ready = 1`.
- `frame_start = 0`, `sent = 0`, `clamped = 0`.
- Reset mid-frame or mid-FIFO discards all buffered pairs; no partial frame is emitted afterwards.

## Timing

- The first edge after reset release receiver-samples idle slot A (the reset value). The transmitter moves to `SLOT_B` on that edge.
- A frame is always 2 cycles; throughput is at most one pair per 2 cycles.
- Latency, with an empty FIFO and no frame in flight: accept at edge `t`.
  - `a` appears on the bus at the first `SLOT_A` entry strictly after `t`, which is edge `t+1` or `t+2`.
  - `b` appears one cycle after `a`.
- `sent` high coincides with the cycle the receiver latches B and raises its frame-complete flag on the following edge.
- Both ends must share `clk` and `rst_n`. Frame phase is never renegotiated.

## Structure

- Shared package, `sensor_bus_pkg`, holds:
  - `SLOT_A`/`SLOT_B` encoding (matches the `ss` value).
  - `SENSOR_W = 8`.
  - Default `MIN_VAL`/`MAX_VAL`.
  - Pair struct type {a, b}.
- One natural sub-module: `pair_fifo`, a synchronous FIFO with push/pop/count/full/empty, parameterised by width and depth.
- The clamp is local combinational logic.

## Test plan

- **Reset idle:** hold `rst_n = 0` for 3 cycles, release, no input. The bus alternates `ss` 0, 1, 0, 1…; `data_bus` stays 0; `frame_start` and `sent` never assert; `in_ready = 1`.
- **Single pair:** accept (a=40, b=75) one cycle after reset release. Required: `ss=0, data_bus=40` with `frame_start`, then `ss=1, data_bus=75` with `sent`. The paired receiver reports s1=40, s2=75 exactly once.
- **Clamp:** accept (0, 200). `clamped` pulses; the bus carries 1 then 100.
- **Back-pressure:** hold `in_valid` with pairs (10,11), (12,13), (14,15), (16,17) continuously. `in_ready` drops when count reaches 2. All four pairs appear in order, one per frame, with no loss or duplication.
- **Simultaneous push/pop:** FIFO holds 1 pair and a push lands on the `SLOT_A`-entry edge. Count stays 1 and order is preserved.
- **Reset mid-operation:** with 2 pairs queued, assert `rst_n = 0` during `SLOT_B`. Next cycle: `data_bus = 0`, `ss = 0`, `sent = 0`. After release only idle frames are sent.
